load_store_unit: RTL and testbench

- Data-memory access stage directly downstream of the ALU in the RV32I core.
- Takes the ALU result as the effective address and rs2 as store data.
- Runs one load or store over a req/ack data-memory bus, stalling the core until the access completes.
- Returns the loaded value, byte-selected and sign/zero-extended, for writeback.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/load_store_unit_if.sv | 22 ++
 rtl/load_store_unit_align.sv | 61 ++++++
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared codes for the load/store unit: RV32I funct3 values, FSM states
// and the access legality rule used by the lane aligner.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

  // Unsigned loads have no store counterpart, so they are illegal with we=1.
  function automatic logic lsu_bad_access(input logic [2:0] f3,
                                          input logic       we,
                                          input logic [1:0] off);
    logic bad;
    case (f3)
      F3_LB:   bad = 1'b0;
      F3_LH:   bad = off[0];
      F3_LW:   bad = |off;
      F3_LBU:  bad = we;
      F3_LHU:  bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: store byte enables and replicated write data,
// access legality, and byte/halfword selection with sign/zero extension on loads.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic            we_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic [XLEN-1:0] rword_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            bad_o,
  output logic [XLEN-1:0] ldata_o
);

  logic signed [7:0]  lbyte;
  logic signed [15:0] lhalf;

  assign bad_o = lsu_bad_access(funct3_i, we_i, addr_lo_i);

  // Reads always fetch the whole word; lanes only matter for writes.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (we_i) begin
      case (funct3_i)
        F3_SB: begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        F3_SH: begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = wdata_i;
        end
      endcase
    end
  end

  always_comb begin
    lbyte   = rword_i[{ld_addr_lo_i, 3'b000} +: 8];
    lhalf   = rword_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
    ldata_o = rword_i;
    case (ld_funct3_i)
      F3_LB:   ldata_o = {{(XLEN-8){lbyte[7]}}, lbyte};
      F3_LH:   ldata_o = {{(XLEN-16){lhalf[15]}}, lhalf};
      F3_LBU:  ldata_o = {{(XLEN-8){1'b0}}, lbyte};
      F3_LHU:  ldata_o = {{(XLEN-16){1'b0}}, lhalf};
      default: ldata_o = rword_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-memory stage: one load or store per request over a req/ack bus,
// stalling the core until the access completes or is rejected as a fault.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      addr,
  input  logic [XLEN-1:0]      wdata,
  output logic                 stall,
  output logic [XLEN-1:0]      rdata,
  output logic                 rdata_valid,
  output logic                 fault,
  load_store_unit_if.master    mem
);

  lsu_state_e      state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;

  logic            stall_c;
  logic            rdata_valid_c;
  logic            fault_c;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata;
  logic            al_bad;
  logic [XLEN-1:0] al_ldata;

  // Load formatting uses the funct3/offset captured at issue, not live inputs.
  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (req_funct3),
    .we_i         (req_we),
    .addr_lo_i    (addr[1:0]),
    .wdata_i      (wdata),
    .ld_funct3_i  (ld_f3_q),
    .ld_addr_lo_i (ld_off_q),
    .rword_i      (mem.mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .bad_o        (al_bad),
    .ldata_o      (al_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ld_f3_q     <= 3'b000;
      ld_off_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    ld_f3_d       = ld_f3_q;
    ld_off_d      = ld_off_q;
    stall_c       = 1'b0;
    rdata_valid_c = 1'b0;
    fault_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          stall_c = 1'b1;
          if (al_bad) begin
            state_d = ST_ERR;
          end else begin
            state_d     = ST_BUS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {addr[XLEN-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            ld_f3_d     = req_funct3;
            ld_off_d    = addr[1:0];
          end
        end
      end
      ST_BUS: begin
        stall_c = 1'b1;
        if (mem.mem_ack && mem_req_q) begin
          mem_req_d = 1'b0;
          if (!mem_we_q) rdata_d = al_ldata;
          state_d = ST_DONE;
        end
      end
      // Core advances on the edge leaving DONE/ERR; a held req_valid is stale.
      ST_DONE: begin
        rdata_valid_c = ~mem_we_q;
        state_d       = ST_IDLE;
      end
      ST_ERR: begin
        fault_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // stall is combinational on req_valid, so it is gated to stay low during reset.
  assign stall         = stall_c & rst_n;
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_c;
  assign fault         = fault_c;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed and random loads/stores
// against a memory responder with random wait states.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] addr, wdata;
  logic        stall, rdata_valid, fault;
  logic [31:0] rdata;

  load_store_unit_if #(.XLEN(32)) bus ();

  load_store_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .addr        (addr),
    .wdata       (wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .fault       (fault),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          flt;
    bit          we;
    logic [31:0] addr_w;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata = 32'h0;
  int          cur_waits = 0;
  logic [31:0] cur_word = 32'h0;
  bit          spur = 1'b0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: RV32I access rules in terms of access size and byte offset.
  function automatic exp_t model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] word);
    exp_t e;
    int nbytes, off;
    bit legal;
    logic [31:0] v;
    e.flt = 1'b0; e.we = we; e.addr_w = a & 32'hFFFF_FFFC;
    e.be = 4'hF; e.wd = wd; e.rd = 32'h0;
    off = int'(a[1:0]);
    case (f3[1:0])
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: nbytes = 0;
    endcase
    legal = (nbytes != 0);
    if (f3[2] && (we || nbytes == 4)) legal = 1'b0;
    if (!legal) begin e.flt = 1'b1; return e; end
    if ((off % nbytes) != 0) begin e.flt = 1'b1; return e; end
    if (we) begin
      e.be = 4'(((1 << nbytes) - 1) << off);
      if (nbytes == 1)      e.wd = (wd & 32'hFF) * 32'h0101_0101;
      else if (nbytes == 2) e.wd = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      v = word >> (8 * off);
      if (nbytes == 1) begin
        v = v & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (nbytes == 2) begin
        v = v & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      e.rd = v;
    end
    return e;
  endfunction

  // Memory responder: acks after cur_waits wait cycles, junk data otherwise.
  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.mem_ack = 1'b0; wcnt = 0;
      end else if (bus.mem_ack) begin
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom();
      end else if (spur) begin
        bus.mem_ack = 1'b1; spur = 1'b0;
      end else if (bus.mem_req && wcnt >= cur_waits) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = cur_word; wcnt = 0;
      end else begin
        if (bus.mem_req) wcnt++;
        bus.mem_rdata = $urandom();
      end
    end
  end

  // Monitor: checks the bus each BUS cycle, pops on ack/fault/rdata_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.mem_req) begin
          if (q.size() == 0) chk("bus_unexpected", {31'b0, bus.mem_req}, 32'h0);
          else if (q[0].flt) chk("bus_on_fault", {31'b0, bus.mem_req}, 32'h0);
          else begin
            chk("mem_we", {31'b0, bus.mem_we}, {31'b0, q[0].we});
            chk("mem_addr", bus.mem_addr, q[0].addr_w);
            chk("mem_be", {28'b0, bus.mem_be}, {28'b0, q[0].be});
            if (q[0].we) begin
              chk("mem_wdata", bus.mem_wdata, q[0].wd);
              if (bus.mem_ack) void'(q.pop_front());
            end
          end
        end
        if (fault || rdata_valid) begin
          if (q.size() == 0) begin
            chk("resp_unexpected", {30'b0, fault, rdata_valid}, 32'h0);
          end else begin
            e = q.pop_front();
            chk("fault", {31'b0, fault}, {31'b0, e.flt});
            chk("rdata_valid", {31'b0, rdata_valid}, {31'b0, !e.flt && !e.we});
            if (!e.flt && !e.we) begin
              chk("rdata", rdata, e.rd);
              last_rdata = e.rd;
            end
          end
        end else begin
          chk("rdata_hold", rdata, last_rdata);
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] word,
                        input int gap);
    exp_t e;
    int n;
    e = model(we, f3, a, wd, word);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; addr = a; wdata = wd;
    cur_waits = waits; cur_word = word;
    q.push_back(e);
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 60) break;
    end
    chk("stall_cycles", n, e.flt ? 32'd1 : 32'(2 + waits));
    if (gap > 0) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (gap - 1) @(posedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t e;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    #12;
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
    chk("rst_fault", {31'b0, fault}, 32'h0);
    chk("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk); #2 rst_n = 1'b1;

    do_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1);
    do_req(1'b1, 3'b000, 32'h103, 32'h000000A5, 3, 32'h0, 1);
    do_req(0, 3'b000, 32'h202, 32'h0, 1, 32'h12F45678, 0);
    do_req(0, 3'b100, 32'h202, 32'h0, 0, 32'h12F45678, 0);
    do_req(0, 3'b001, 32'h202, 32'h0, 2, 32'h12F45678, 1);
    do_req(0, 3'b010, 32'h006, 32'h0, 0, 32'h0, 1);
    do_req(0, 3'b011, 32'h200, 32'h0, 0, 32'h0, 1);
    do_req(1'b1, 3'b001, 32'h302, 32'h0000BEEF, 1, 32'h0, 0);
    do_req(0, 3'b101, 32'h302, 32'h0, 0, 32'h8001_7FFF, 1);

    // Spurious ack while idle must be ignored.
    @(posedge clk); #1 spur = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("spur_stall", {31'b0, stall}, 32'h0);
    end

    // Reset while a load waits on the bus.
    e = model(0, 3'b010, 32'h40, 32'h0, 32'h5555_AAAA);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; addr = 32'h40;
    cur_waits = 20; cur_word = 32'h5555_AAAA;
    q.push_back(e);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", {31'b0, bus.mem_req}, 32'h0);
    chk("midrst_stall", {31'b0, stall}, 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    chk("midrst_mem_be", {28'b0, bus.mem_be}, 32'h0);
    q.delete();
    last_rdata = 32'h0;
    req_valid = 1'b0;
    @(negedge clk); @(negedge clk); #2 rst_n = 1'b1;
    do_req(0, 3'b010, 32'h44, 32'h0, 1, 32'hCAFE_F00D, 0);
    do_req(1'b1, 3'b010, 32'h48, 32'h1234_5678, 0, 32'h0, 1);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      ra = {20'h0, 10'($urandom()), 2'($urandom())};
      do_req(1'($urandom()), 3'($urandom()), ra, $urandom(), $urandom_range(0, 3),
             $urandom(), $urandom_range(0, 2));
    end

    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("sb_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
